// File: rtl/data_mem_ctrl_pkg.sv
// mem_pkg: shared definitions for the data memory controller.
//   SZ_*     : req_size encodings (byte / half / word / illegal)
//   state_t  : controller state (post-reset clear sweep, then idle/serving)
//   be_from  : byte-lane enable mask for a store of a given size and address
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// mem_load_align: combinational load lane select and extension.
//   word        in  32  raw word read from the array
//   addr_lo     in  2   byte offset of the load within the word
//   size        in  2   access size (SZ_B / SZ_H / SZ_W)
//   is_unsigned in  1   1: zero-extend, 0: sign-extend (byte/half only)
//   data        out 32  extended load result (0 for the illegal size)
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_B:    data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      SZ_H:    data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      SZ_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable word memory for the load/store path.
//   clk, rst (async, active-low)
//   req_valid/req_ready  : request handshake (one accept per cycle when idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid/rsp_rdata/rsp_err : response, one cycle after accept
//   init_done            : post-reset clear sweep complete
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = ADDR_W - 2;
  localparam state_t ST_RST = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

  logic [31:0] mem [0:DEPTH-1];

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_we_q, rsp_we_d;
  logic [1:0]    rsp_lane_q, rsp_lane_d;
  logic [1:0]    rsp_size_q, rsp_size_d;
  logic          rsp_uns_q, rsp_uns_d;
  logic [31:0]   rd_word_q;

  logic [IW-1:0] widx;
  logic          req_err;
  logic          accept;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [31:0]   load_data;

  assign widx = req_addr[ADDR_W-1:2];

  // Gating with rst keeps ready low during reset even when no sweep is configured.
  assign req_ready = rst & (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  assign req_err = (req_size == SZ_X)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                 | (32'(widx) >= DEPTH);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d     = ST_IDLE;
        init_done_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end

    rsp_valid_d = accept;
    rsp_err_d   = accept & req_err;
    rsp_we_d    = req_we;
    rsp_lane_d  = req_addr[1:0];
    rsp_size_d  = req_size;
    rsp_uns_d   = req_unsigned;
  end

  // Sweep and store share one write port; the sweep owns it while in INIT
  // (no requests can be accepted then). Narrow stores replicate their data
  // across lanes so the byte enables alone pick the destination.
  always_comb begin
    mem_be  = 4'b0000;
    mem_idx = widx[AW-1:0];
    case (req_size)
      SZ_B:    mem_wdata = {4{req_wdata[7:0]}};
      SZ_H:    mem_wdata = {2{req_wdata[15:0]}};
      default: mem_wdata = req_wdata;
    endcase
    if (state_q == ST_INIT) begin
      if (rst) begin
        mem_be = 4'b1111;
      end
      mem_idx   = clr_cnt_q;
      mem_wdata = '0;
    end else if (accept && req_we && !req_err) begin
      mem_be = be_from(req_size, req_addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (accept) begin
      rd_word_q <= mem[widx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RST;
      clr_cnt_q   <= '0;
      init_done_q <= !CLEAR_ON_RESET;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_lane_q  <= '0;
      rsp_size_q  <= '0;
      rsp_uns_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      rsp_lane_q  <= rsp_lane_d;
      rsp_size_q  <= rsp_size_d;
      rsp_uns_q   <= rsp_uns_d;
    end
  end

  mem_load_align u_align (
    .word        (rd_word_q),
    .addr_lo     (rsp_lane_q),
    .size        (rsp_size_q),
    .is_unsigned (rsp_uns_q),
    .data        (load_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? load_data : '0;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_assert = 0;
  int n_fail   = 0;

  data_mem_ctrl #(
    .ADDR_W         (16),
    .DEPTH          (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request: drive on negedge, accepted at the next posedge,
  // response sampled 1 time unit later.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
    chk({tag, "_rdata"}, rsp_rdata,      exp_rdata);
  endtask

  logic [31:0] p_wdata [4];
  logic        p_we    [4];
  logic [31:0] p_exp   [4];
  int          stall;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // 1: reset values, then sweep of 16 words
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",     32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep_ready_%0d", i), 32'(req_ready), 32'(i == 15));
    end
    chk("sweep_init_done", 32'(init_done), 32'd1);
    do_req("lw_3c", 1'b0, 2'b10, 1'b0, 16'h003C, 32'h0, 1'b0, 32'h0);

    // 2: byte stores and byte loads
    do_req("sw_10",  1'b1, 2'b10, 1'b0, 16'h0010, 32'h11223344, 1'b0, 32'h0);
    do_req("sb_11",  1'b1, 2'b00, 1'b0, 16'h0011, 32'h000000AA, 1'b0, 32'h0);
    do_req("lw_10",  1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 1'b0, 32'h1122AA44);
    do_req("lbu_11", 1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, 1'b0, 32'h000000AA);
    do_req("lb_11",  1'b0, 2'b00, 1'b0, 16'h0011, 32'h0, 1'b0, 32'hFFFFFFAA);

    // 3: half stores/loads and misaligned half
    do_req("sh_22",  1'b1, 2'b01, 1'b0, 16'h0022, 32'h00008001, 1'b0, 32'h0);
    do_req("lh_22",  1'b0, 2'b01, 1'b0, 16'h0022, 32'h0, 1'b0, 32'hFFFF8001);
    do_req("lhu_22", 1'b0, 2'b01, 1'b1, 16'h0022, 32'h0, 1'b0, 32'h00008001);
    do_req("lh_21",  1'b0, 2'b01, 1'b0, 16'h0021, 32'h0, 1'b1, 32'h0);
    do_req("sh_21",  1'b1, 2'b01, 1'b0, 16'h0021, 32'h0000BEEF, 1'b1, 32'h0);
    do_req("lw_20",  1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 1'b0, 32'h80010000);

    // 4: error cases
    do_req("lw_02",  1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, 1'b1, 32'h0);
    do_req("sz_11",  1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, 1'b1, 32'h0);
    do_req("lw_40",  1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, 1'b1, 32'h0);
    do_req("sw_06",  1'b1, 2'b10, 1'b0, 16'h0006, 32'hDEADBEEF, 1'b1, 32'h0);
    do_req("lw_04",  1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, 1'b0, 32'h0);

    // 5: back-to-back SW, LW, SW, LW to word 0x30
    p_we[0] = 1'b1; p_wdata[0] = 32'hCAFEF00D; p_exp[0] = 32'h0;
    p_we[1] = 1'b0; p_wdata[1] = 32'h0;        p_exp[1] = 32'hCAFEF00D;
    p_we[2] = 1'b1; p_wdata[2] = 32'h12345678; p_exp[2] = 32'h0;
    p_we[3] = 1'b0; p_wdata[3] = 32'h0;        p_exp[3] = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = p_we[i]; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = 16'h0030; req_wdata = p_wdata[i];
      @(posedge clk); #1;
      chk($sformatf("pipe_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("pipe_rdata_%0d", i), rsp_rdata, p_exp[i]);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pipe_idle_valid", 32'(rsp_valid), 32'd0);

    // 6: reset while a response is showing
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0030;
    @(posedge clk); #1;
    chk("mid_valid_before", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_valid_after", 32'(rsp_valid), 32'd0);
    chk("mid_ready",       32'(req_ready), 32'd0);
    chk("mid_init_done",   32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // Request held throughout: ready after 16 edges, accepted on edge 17.
    stall = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        stall = c;
        break;
      end
    end
    req_valid = 1'b0;
    chk("mid_stall_cycles", 32'(stall), 32'd17);
    chk("mid_rdata_swept",  rsp_rdata,  32'h0);
    chk("mid_init_done2",   32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
